// File: rtl/multi_button_io_handler.sv
// Front-panel button debounce, one-hot mode stepping with comm-deferral, and activity LED stretch.
// Optional long-press detection is enabled by defining LONG_PRESS_EN.
module multi_button_io_handler #(
  parameter int NUM_BTNS             = 4,
  parameter int MODE_WIDTH           = 4,
  parameter bit BUTTONS_ACTIVE_LOW   = 1'b1,
  parameter int SYS_FREQ_HZ          = 12_000_000,
  parameter int DEBOUNCE_DURATION_US = 1_000,
  parameter int LONG_PRESS_MS        = 1_000,
  parameter int ACT_LED_HOLD_MS      = 50
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NUM_BTNS-1:0]   btn_in,
  input  logic                  comm_active,
  output logic [NUM_BTNS-1:0]   btn_state,
  output logic [NUM_BTNS-1:0]   btn_press,
  output logic [NUM_BTNS-1:0]   btn_long,
  output logic [MODE_WIDTH-1:0] mode_select,
  output logic                  mode_changed,
  output logic [MODE_WIDTH-1:0] mode_leds,
  output logic                  comm_active_led
);

  localparam int DEB_CNT  = DEBOUNCE_DURATION_US * (SYS_FREQ_HZ / 1_000_000);
  localparam int DEB_EFF  = (DEB_CNT < 1) ? 1 : DEB_CNT;
  localparam int DEB_W    = $clog2(DEB_EFF + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_EFF - 1);

  localparam int HOLD_CNT = ACT_LED_HOLD_MS * (SYS_FREQ_HZ / 1_000);
  localparam int HOLD_W   = $clog2(HOLD_CNT + 2);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CNT);

  localparam logic [NUM_BTNS-1:0]   IDLE_RAW = {NUM_BTNS{BUTTONS_ACTIVE_LOW}};
  localparam logic [MODE_WIDTH-1:0] MODE_ONE = MODE_WIDTH'(1);

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_NEXT,
    REQ_PREV,
    REQ_HOME
  } req_t;

  logic [NUM_BTNS-1:0] sync_q1;
  logic [NUM_BTNS-1:0] sync_q2;
  logic [NUM_BTNS-1:0] level;
  logic [DEB_W-1:0]    deb_cnt [NUM_BTNS];
  logic [HOLD_W-1:0]   hold_cnt;
  logic                long_home;
  req_t                req;
  req_t                pending;
  req_t                eff_req;

  // Synchronisers reset to the released pin level so no phantom press follows reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q1 <= IDLE_RAW;
      sync_q2 <= IDLE_RAW;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  assign level = sync_q2 ^ IDLE_RAW;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      btn_state <= '0;
      btn_press <= '0;
      for (int i = 0; i < NUM_BTNS; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        btn_press[i] <= 1'b0;
        if (level[i] == btn_state[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          btn_state[i] <= level[i];
          btn_press[i] <= level[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam int LONG_CNT = LONG_PRESS_MS * (SYS_FREQ_HZ / 1_000);
  localparam int LONG_EFF = (LONG_CNT < 1) ? 1 : LONG_CNT;
  localparam int LONG_W   = $clog2(LONG_EFF + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_EFF - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_EFF);

  logic [LONG_W-1:0] long_cnt [NUM_BTNS];

  // Counter parks at LONG_SAT so a held button fires only once until released.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      btn_long <= '0;
      for (int i = 0; i < NUM_BTNS; i++) long_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        btn_long[i] <= 1'b0;
        if (!btn_state[i]) begin
          long_cnt[i] <= '0;
        end else if (long_cnt[i] != LONG_SAT) begin
          long_cnt[i] <= long_cnt[i] + 1'b1;
          btn_long[i] <= (long_cnt[i] == LONG_LAST);
        end
      end
    end
  end

  assign long_home = btn_long[0];
`else
  assign btn_long  = '0;
  assign long_home = 1'b0;
`endif

  always_comb begin
    req = REQ_NONE;
    if (long_home)                        req = REQ_HOME;
    else if (btn_press[0] && !btn_press[1]) req = REQ_NEXT;
    else if (btn_press[1] && !btn_press[0]) req = REQ_PREV;
  end

  // A fresh request in the release cycle supersedes whatever was deferred.
  assign eff_req = (req != REQ_NONE) ? req : pending;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mode_select  <= MODE_ONE;
      mode_changed <= 1'b0;
      pending      <= REQ_NONE;
    end else begin
      mode_changed <= 1'b0;
      if (comm_active) begin
        if (req != REQ_NONE) pending <= req;
      end else begin
        pending <= REQ_NONE;
        case (eff_req)
          REQ_NEXT: begin
            mode_select  <= {mode_select[MODE_WIDTH-2:0], mode_select[MODE_WIDTH-1]};
            mode_changed <= 1'b1;
          end
          REQ_PREV: begin
            mode_select  <= {mode_select[0], mode_select[MODE_WIDTH-1:1]};
            mode_changed <= 1'b1;
          end
          REQ_HOME: begin
            mode_select  <= MODE_ONE;
            mode_changed <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mode_leds = mode_select;

  always_ff @(posedge sys_clk) begin
    if (rst)                   hold_cnt <= '0;
    else if (comm_active)      hold_cnt <= HOLD_LOAD;
    else if (hold_cnt != '0)   hold_cnt <= hold_cnt - 1'b1;
  end

  assign comm_active_led = comm_active | (hold_cnt != '0);

endmodule

// File: tb/tb_multi_button_io_handler.sv
// Directed bench: debounce timing, mode stepping, deferral, LED stretch, reset, long press.
module tb_multi_button_io_handler;

  localparam int SYS_FREQ = 1_000_000;
  localparam int HOLD     = 1 * (SYS_FREQ / 1_000);
  localparam int LONG     = 1 * (SYS_FREQ / 1_000);

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic       comm_active;
  logic [3:0] btn_state;
  logic [3:0] btn_press;
  logic [3:0] btn_long;
  logic [3:0] mode_select;
  logic       mode_changed;
  logic [3:0] mode_leds;
  logic       comm_active_led;

  int total = 0;
  int bad   = 0;

  multi_button_io_handler #(
    .NUM_BTNS(4),
    .MODE_WIDTH(4),
    .BUTTONS_ACTIVE_LOW(1'b1),
    .SYS_FREQ_HZ(SYS_FREQ),
    .DEBOUNCE_DURATION_US(4),
    .LONG_PRESS_MS(1),
    .ACT_LED_HOLD_MS(1)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .btn_in(btn_in),
    .comm_active(comm_active),
    .btn_state(btn_state),
    .btn_press(btn_press),
    .btn_long(btn_long),
    .mode_select(mode_select),
    .mode_changed(mode_changed),
    .mode_leds(mode_leds),
    .comm_active_led(comm_active_led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_in = 4'b1111;
    comm_active = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Press (active-low) the buttons in mask for 'cycles', release, and let debounce settle.
  task automatic hold_btns(input logic [3:0] mask, input int cycles);
    btn_in = ~mask;
    repeat (cycles) tick();
    btn_in = 4'b1111;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (btn_state !== 4'b0000) begin bad++; $display("FAIL reset_btn_state got=%b exp=%b", btn_state, 4'b0000); end
    total++; if (btn_press !== 4'b0000) begin bad++; $display("FAIL reset_btn_press got=%b exp=%b", btn_press, 4'b0000); end
    total++; if (btn_long !== 4'b0000) begin bad++; $display("FAIL reset_btn_long got=%b exp=%b", btn_long, 4'b0000); end
    total++; if (mode_select !== 4'b0001) begin bad++; $display("FAIL reset_mode got=%b exp=%b", mode_select, 4'b0001); end
    total++; if (mode_leds !== 4'b0001) begin bad++; $display("FAIL reset_leds got=%b exp=%b", mode_leds, 4'b0001); end
    total++; if (mode_changed !== 1'b0) begin bad++; $display("FAIL reset_mode_changed got=%b exp=0", mode_changed); end
    total++; if (comm_active_led !== 1'b0) begin bad++; $display("FAIL reset_act_led got=%b exp=0", comm_active_led); end
  endtask

  task automatic test_press();
    int noise;
    do_reset();
    btn_in = 4'b1110;
    repeat (5) tick();
    total++; if (btn_state !== 4'b0000) begin bad++; $display("FAIL deb_early got=%b exp=%b", btn_state, 4'b0000); end
    tick();
    total++; if (btn_state !== 4'b0001) begin bad++; $display("FAIL deb_cycle6 got=%b exp=%b", btn_state, 4'b0001); end
    total++; if (btn_press !== 4'b0001) begin bad++; $display("FAIL press_pulse got=%b exp=%b", btn_press, 4'b0001); end
    total++; if (mode_select !== 4'b0001) begin bad++; $display("FAIL mode_before got=%b exp=%b", mode_select, 4'b0001); end
    tick();
    total++; if (mode_select !== 4'b0010 || mode_changed !== 1'b1) begin bad++; $display("FAIL mode_step got=%b/%b exp=0010/1", mode_select, mode_changed); end
    total++; if (btn_press !== 4'b0000) begin bad++; $display("FAIL press_one_cycle got=%b exp=%b", btn_press, 4'b0000); end
    tick();
    total++; if (mode_changed !== 1'b0) begin bad++; $display("FAIL mode_changed_one_cycle got=%b exp=0", mode_changed); end
    repeat (2) tick();
    btn_in = 4'b1111;
    repeat (10) tick();
    total++; if (btn_state !== 4'b0000 || mode_leds !== 4'b0010) begin bad++; $display("FAIL release got=%b/%b exp=0000/0010", btn_state, mode_leds); end
    // 3-cycle glitch on btn 1 must be filtered.
    noise = 0;
    btn_in = 4'b1101;
    repeat (3) tick();
    btn_in = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btn_state != 4'b0000 || btn_press != 4'b0000 || mode_changed) noise++;
    end
    total++; if (noise !== 0 || mode_select !== 4'b0010) begin bad++; $display("FAIL glitch noise=%0d mode=%b exp=0/0010", noise, mode_select); end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_rot [4];
    exp_rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      hold_btns(4'b0001, 10);
      total++; if (mode_select !== exp_rot[i]) begin bad++; $display("FAIL rotate_next step=%0d got=%b exp=%b", i, mode_select, exp_rot[i]); end
    end
    hold_btns(4'b0010, 10);
    total++; if (mode_select !== 4'b1000) begin bad++; $display("FAIL rotate_prev_wrap got=%b exp=%b", mode_select, 4'b1000); end
  endtask

  task automatic test_defer();
    do_reset();
    comm_active = 1'b1;
    hold_btns(4'b0001, 10);
    hold_btns(4'b0010, 10);
    total++; if (mode_select !== 4'b0001) begin bad++; $display("FAIL defer_hold got=%b exp=%b", mode_select, 4'b0001); end
    comm_active = 1'b0;
    tick();
    total++; if (mode_select !== 4'b1000 || mode_changed !== 1'b1) begin bad++; $display("FAIL defer_apply got=%b/%b exp=1000/1", mode_select, mode_changed); end
    tick();
    total++; if (mode_select !== 4'b1000 || mode_changed !== 1'b0) begin bad++; $display("FAIL defer_once got=%b/%b exp=1000/0", mode_select, mode_changed); end
  endtask

  task automatic test_same_cycle();
    int chg;
    chg = 0;
    do_reset();
    btn_in = 4'b1100;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mode_changed) chg++;
      if (i == 6) begin
        total++; if (btn_press !== 4'b0011) begin bad++; $display("FAIL both_press got=%b exp=%b", btn_press, 4'b0011); end
      end
      if (i == 10) btn_in = 4'b1111;
    end
    total++; if (chg !== 0 || mode_select !== 4'b0001) begin bad++; $display("FAIL both_no_change chg=%0d mode=%b exp=0/0001", chg, mode_select); end
  endtask

  task automatic test_led_and_reset();
    int n;
    int chg;
    do_reset();
    comm_active = 1'b1;
    #1;
    total++; if (comm_active_led !== 1'b1) begin bad++; $display("FAIL led_immediate got=%b exp=1", comm_active_led); end
    n = 1;
    tick();
    comm_active = 1'b0;
    while (comm_active_led && n < 3000) begin
      n++;
      tick();
    end
    total++; if (n !== HOLD + 1) begin bad++; $display("FAIL led_stretch got=%0d exp=%0d", n, HOLD + 1); end
    // Pending request must be discarded by reset.
    comm_active = 1'b1;
    hold_btns(4'b0001, 10);
    rst = 1'b1;
    comm_active = 1'b0;
    tick();
    total++; if (comm_active_led !== 1'b0 || mode_select !== 4'b0001) begin bad++; $display("FAIL rst_defer led=%b mode=%b exp=0/0001", comm_active_led, mode_select); end
    rst = 1'b0;
    chg = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mode_changed) chg++;
    end
    total++; if (chg !== 0 || mode_select !== 4'b0001) begin bad++; $display("FAIL rst_pending_lost chg=%0d mode=%b exp=0/0001", chg, mode_select); end
  endtask

  task automatic test_long();
    int longs;
    int long_at;
    int exp_longs;
    logic [3:0] exp_mode;
`ifdef LONG_PRESS_EN
    exp_longs = 1;
    exp_mode  = 4'b0001;
`else
    exp_longs = 0;
    exp_mode  = 4'b1000;
`endif
    longs = 0;
    long_at = 0;
    do_reset();
    hold_btns(4'b0001, 10);
    hold_btns(4'b0001, 10);
    total++; if (mode_select !== 4'b0100) begin bad++; $display("FAIL long_setup got=%b exp=%b", mode_select, 4'b0100); end
    btn_in = 4'b1110;
    for (int i = 1; i <= LONG + 30; i++) begin
      tick();
      if (btn_long != 4'b0000) begin
        longs++;
        long_at = i;
      end
    end
    total++; if (longs !== exp_longs) begin bad++; $display("FAIL long_count got=%0d exp=%0d", longs, exp_longs); end
    total++; if (mode_select !== exp_mode) begin bad++; $display("FAIL long_mode got=%b exp=%b", mode_select, exp_mode); end
`ifdef LONG_PRESS_EN
    total++; if (long_at !== LONG + 6) begin bad++; $display("FAIL long_timing got=%0d exp=%0d", long_at, LONG + 6); end
`endif
    btn_in = 4'b1111;
    repeat (10) tick();
  endtask

  initial begin
    rst = 1'b1;
    btn_in = 4'b1111;
    comm_active = 1'b0;
    test_reset();
    test_press();
    test_rotate();
    test_defer();
    test_same_cycle();
    test_led_and_reset();
    test_long();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
